exa_axis_vc_steer: RTL and testbench

// - Upstream feeder of exa_crosb_s2e_with_VCs: takes AXI-Stream packets from the traffic source and assigns each one a VC.
// - Presents each packet to the s2e stage with o_output_vc held stable from the first beat to the tlast beat.
// - A packet is never started towards a VC whose s2e FIFO reports full.
// - VC is either requested per packet (s_tdest) or chosen round-robin among non-full VCs (auto mode).

---
 rtl/exa_vc_pkg.sv | 44 ++++
 rtl/exa_axis_skid2.sv | 50 +++++
 rtl/exa_axis_vc_steer.sv | 112 +++++++++++
 tb/tb_exa_axis_vc_steer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exa_vc_pkg.sv
// Shared VC steering types, sizes and round-robin helper.
// Used by the AXIS VC steer front end of the s2e crossbar.
package exa_vc_pkg;

  localparam int PRIO_NUM = 2;
  localparam int VC_NUM   = 2;
  localparam int NVC      = PRIO_NUM * VC_NUM;
  localparam int VC_W     = (NVC > 1) ? $clog2(NVC) : 1;

  typedef logic [VC_W-1:0] vc_t;

  typedef struct packed {
    logic found;
    vc_t  vc;
  } pick_t;

  typedef enum logic {
    SELECT,
    STREAM
  } steer_state_t;

  // First non-full VC scanning from ptr+1, wrapping
  // explicitly so NVC need not be a power of two.
  function automatic pick_t rr_pick(
    input logic [NVC-1:0] full_mask,
    input vc_t            ptr
  );
    pick_t r;
    int    idx;
    vc_t   v;
    r = '0;
    for (int i = 1; i <= NVC; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NVC) idx = idx - NVC;
      v = vc_t'(idx);
      if (!r.found && !full_mask[v]) begin
        r.found = 1'b1;
        r.vc    = v;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/exa_axis_skid2.sv
// Generic 2-entry AXIS skid buffer (1-cycle latency, full rate).
// Ports: s_data/s_valid/s_ready in, m_data/m_valid/m_ready out, empty.
module exa_axis_skid2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         empty
);

  logic [W-1:0] sk_data;
  logic         sk_valid;
  logic         s_fire;

  assign s_ready = ~sk_valid;
  assign s_fire  = s_valid & s_ready;
  assign empty   = ~m_valid & ~sk_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_data   <= '0;
      m_valid  <= 1'b0;
      sk_data  <= '0;
      sk_valid <= 1'b0;
    end else if (sk_valid) begin
      // Output is necessarily valid; refill it from the skid.
      if (m_ready) begin
        m_data   <= sk_data;
        sk_valid <= 1'b0;
      end
    end else if (s_fire) begin
      if (!m_valid || m_ready) begin
        m_data  <= s_data;
        m_valid <= 1'b1;
      end else begin
        sk_data  <= s_data;
        sk_valid <= 1'b1;
      end
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/exa_axis_vc_steer.sv
// Assigns a VC to each AXIS packet (manual tdest or round-robin)
// and feeds the s2e stage with the VC held for the whole packet.
// Ports: clk/reset, i_auto_vc, s_* (slave AXIS), m_* (master AXIS),
//        o_output_vc, i_fifo_full, o_busy, o_stall_cnt.
module exa_axis_vc_steer
  import exa_vc_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_auto_vc,
  input  logic [DATA_W-1:0]  s_tdata,
  input  logic               s_tvalid,
  output logic               s_tready,
  input  logic               s_tlast,
  input  logic [VC_W-1:0]    s_tdest,
  output logic [DATA_W-1:0]  m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast,
  output logic [VC_W-1:0]    o_output_vc,
  input  logic [NVC-1:0]     i_fifo_full,
  output logic               o_busy,
  output logic [STALL_W-1:0] o_stall_cnt
);

  steer_state_t state_q, state_d;

  vc_t                ptr_q;
  vc_t                vc_q;
  logic [STALL_W-1:0] stall_q;

  pick_t rr;
  vc_t   cand;
  logic  found;
  logic  start;
  logic  beat;

  logic              sl_ready;
  logic              sl_empty;
  logic [DATA_W:0]   sl_out;

  assign rr = rr_pick(i_fifo_full, ptr_q);

  always_comb begin
    cand  = s_tdest;
    found = ~i_fifo_full[s_tdest];
    if (i_auto_vc) begin
      cand  = rr.vc;
      found = rr.found;
    end
  end

  // Slice must be empty so the VC never changes
  // under beats still waiting to leave.
  assign start = (state_q == SELECT) & s_tvalid
               & found & sl_empty;

  assign s_tready = (state_q == STREAM) & sl_ready;
  assign beat     = s_tvalid & s_tready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SELECT: if (start) state_d = STREAM;
      STREAM: if (beat && s_tlast) state_d = SELECT;
      default: state_d = SELECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SELECT;
      ptr_q   <= vc_t'(NVC - 1);
      vc_q    <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        vc_q  <= cand;
        ptr_q <= cand;
      end
      if ((state_q == SELECT) && s_tvalid && !found
          && (stall_q != {STALL_W{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  exa_axis_skid2 #(
    .W (DATA_W + 1)
  ) u_slice (
    .clk     (clk),
    .reset   (reset),
    .s_data  ({s_tdata, s_tlast}),
    .s_valid (beat),
    .s_ready (sl_ready),
    .m_data  (sl_out),
    .m_valid (m_tvalid),
    .m_ready (m_tready),
    .empty   (sl_empty)
  );

  assign m_tdata     = sl_out[DATA_W:1];
  assign m_tlast     = sl_out[0];
  assign o_output_vc = vc_q;
  assign o_busy      = (state_q == STREAM) | ~sl_empty;
  assign o_stall_cnt = stall_q;

endmodule

// File: tb/tb_exa_axis_vc_steer.sv
// Directed bench for exa_axis_vc_steer with a beat scoreboard.
// Expected beats/VCs are queued at source acceptance.
module tb_exa_axis_vc_steer;
  import exa_vc_pkg::*;

  localparam int DW = 128;
  localparam int SW = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           i_auto_vc = 1'b0;
  logic [DW-1:0]  s_tdata = '0;
  logic           s_tvalid = 1'b0;
  logic           s_tready;
  logic           s_tlast = 1'b0;
  vc_t            s_tdest = '0;
  logic [DW-1:0]  m_tdata;
  logic           m_tvalid;
  logic           m_tready = 1'b1;
  logic           m_tlast;
  vc_t            o_output_vc;
  logic [NVC-1:0] i_fifo_full = '0;
  logic           o_busy;
  logic [SW-1:0]  o_stall_cnt;

  exa_axis_vc_steer #(
    .DATA_W  (DW),
    .STALL_W (SW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_auto_vc   (i_auto_vc),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tlast     (s_tlast),
    .s_tdest     (s_tdest),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .o_output_vc (o_output_vc),
    .i_fifo_full (i_fifo_full),
    .o_busy      (o_busy),
    .o_stall_cnt (o_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    vc_t           vc;
  } exp_t;

  exp_t sb[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rise_cyc = -1;
  int last_cyc = -1;
  int nbeats = 0;
  logic rnd_en = 1'b0;
  logic [31:0] seq = 32'h100;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    m_tready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(string tag, logic [DW-1:0] obs,
                       logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sink monitor: scoreboard pop and AXIS hold rule.
  logic          p_stall = 1'b0;
  logic [DW-1:0] p_d;
  logic          p_l;
  vc_t           p_vc;

  always @(negedge clk) begin
    if (reset) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        check("hold_valid", DW'(m_tvalid), 1);
        check("hold_data", m_tdata, p_d);
        check("hold_last", DW'(m_tlast), DW'(p_l));
        check("hold_vc", DW'(o_output_vc), DW'(p_vc));
      end
      if (m_tvalid && rise_cyc < 0) rise_cyc = cyc;
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_beat", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("m_tdata", m_tdata, e.d);
          check("m_tlast", DW'(m_tlast), DW'(e.l));
          check("o_output_vc", DW'(o_output_vc), DW'(e.vc));
        end
        nbeats++;
        if (m_tlast) last_cyc = cyc;
      end
      p_stall = m_tvalid && !m_tready;
      p_d     = m_tdata;
      p_l     = m_tlast;
      p_vc    = o_output_vc;
    end
  end

  task automatic do_reset();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  // Drives one packet; abort_at leaves that beat on the bus and
  // returns; ev_at applies ev_full before driving that beat.
  task automatic send_pkt(int n, logic au, vc_t dest, vc_t evc,
                          int abort_at, int ev_at,
                          logic [NVC-1:0] ev_full);
    logic acc;
    int   t;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (i == ev_at) i_fifo_full = ev_full;
      s_tvalid  = 1'b1;
      s_tdata   = DW'(seq);
      s_tlast   = (i == n - 1);
      i_auto_vc = au;
      s_tdest   = dest;
      if (abort_at > 0 && i == abort_at) return;
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 300) begin
        @(negedge clk);
        acc = s_tready;
        if (acc) begin
          e.d  = s_tdata;
          e.l  = s_tlast;
          e.vc = evc;
          sb.push_back(e);
        end
        @(posedge clk);
        #1;
        t++;
      end
      if (!acc) begin
        check("src_timeout", 0, 1);
        s_tvalid = 1'b0;
        return;
      end
      seq++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || o_busy) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain", DW'(sb.size()), 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int c0;
    int nb0;

    // Reset values
    #2;
    check("rst_s_tready", DW'(s_tready), 0);
    check("rst_m_tvalid", DW'(m_tvalid), 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_stall", DW'(o_stall_cnt), 0);
    do_reset();

    // Manual VC2, 18 beats, full rate
    rise_cyc = -1;
    k = cyc;
    send_pkt(18, 1'b0, 2'd2, 2'd2, 0, -1, '0);
    drain();
    check("first_latency", DW'(rise_cyc - k), 2);
    check("full_rate", DW'(last_cyc - rise_cyc), 17);

    // Auto, 5 back-to-back packets
    do_reset();
    send_pkt(4, 1'b1, 2'd0, 2'd0, 0, -1, '0);
    send_pkt(4, 1'b1, 2'd0, 2'd1, 0, -1, '0);
    send_pkt(4, 1'b1, 2'd0, 2'd2, 0, -1, '0);
    send_pkt(4, 1'b1, 2'd0, 2'd3, 0, -1, '0);
    send_pkt(4, 1'b1, 2'd0, 2'd0, 0, -1, '0);
    drain();

    // Auto with VC0/VC2 full, then all full, then VC2 frees
    do_reset();
    i_fifo_full = 4'b0101;
    send_pkt(3, 1'b1, 2'd0, 2'd1, 0, -1, '0);
    send_pkt(3, 1'b1, 2'd0, 2'd3, 0, -1, '0);
    send_pkt(3, 1'b1, 2'd0, 2'd1, 0, -1, '0);
    i_fifo_full = 4'b1111;
    s_tvalid = 1'b1;
    s_tdata  = DW'(seq);
    s_tlast  = 1'b0;
    @(negedge clk);
    c0 = int'(o_stall_cnt);
    repeat (5) begin
      @(negedge clk);
      check("allfull_s_tready", DW'(s_tready), 0);
    end
    check("stall_cnt", DW'(o_stall_cnt), DW'(c0 + 5));
    @(posedge clk);
    #1;
    i_fifo_full = 4'b1011;
    send_pkt(3, 1'b1, 2'd0, 2'd2, 0, -1, '0);
    drain();

    // Full rises mid-packet; next packets avoid that VC
    do_reset();
    i_fifo_full = '0;
    send_pkt(8, 1'b1, 2'd0, 2'd0, 0, 2, 4'b0001);
    send_pkt(4, 1'b1, 2'd0, 2'd1, 0, -1, '0);
    drain();
    s_tvalid  = 1'b1;
    s_tdata   = DW'(seq);
    i_auto_vc = 1'b0;
    s_tdest   = 2'd0;
    @(negedge clk);
    c0 = int'(o_stall_cnt);
    repeat (4) begin
      @(negedge clk);
      check("manual_block", DW'(s_tready), 0);
    end
    check("manual_stall", DW'(o_stall_cnt), DW'(c0 + 4));
    @(posedge clk);
    #1;
    i_fifo_full = '0;
    send_pkt(3, 1'b0, 2'd0, 2'd0, 0, -1, '0);
    drain();

    // Random m_tready over 18 beats
    do_reset();
    nb0 = nbeats;
    rnd_en = 1'b1;
    send_pkt(18, 1'b0, 2'd1, 2'd1, 0, -1, '0);
    drain();
    rnd_en = 1'b0;
    check("rnd_beats", DW'(nbeats - nb0), 18);

    // Reset at beat 5 of 10, then clean auto packet on VC0
    do_reset();
    send_pkt(10, 1'b0, 2'd2, 2'd2, 4, -1, '0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_s_tready", DW'(s_tready), 0);
    check("mid_rst_m_tvalid", DW'(m_tvalid), 0);
    check("mid_rst_m_tlast", DW'(m_tlast), 0);
    check("mid_rst_m_tdata", m_tdata, 0);
    check("mid_rst_vc", DW'(o_output_vc), 0);
    check("mid_rst_busy", DW'(o_busy), 0);
    check("mid_rst_stall", DW'(o_stall_cnt), 0);
    s_tvalid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    seq++;
    send_pkt(4, 1'b1, 2'd3, 2'd0, 0, -1, '0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
